pcpi_result_serializer: RTL and testbench

- Downstream stage of the fused matrix-multiply PCPI coprocessor.
- Captures each 32-bit write-back result (pcpi_rd), qualified by pcpi_ready and pcpi_wr, into a small result FIFO.
- Streams each result to the off-chip host as eight 4-bit nibbles over a valid/ack handshake.
- Mirrors the 4-bit instruction-segment loader on the input side, so the host reads results through the same narrow pin budget it uses to write instructions.

---
 rtl/pcpi_result_serializer.sv | 110 +++++++++++
 tb/tb_pcpi_result_serializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_result_serializer.sv
// Buffers PCPI write-back results in a small FIFO and streams each one to the
// host as LSB-first nibbles over a valid/ack handshake.
module pcpi_result_serializer #(
   parameter int DATA_W = 32,
   parameter int NIB_W  = 4,
   parameter int DEPTH  = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   pcpi_ready,
   input  logic                                   pcpi_wr,
   input  logic [DATA_W-1:0]                      pcpi_rd,
   output logic                                   busy,
   output logic                                   nib_valid,
   output logic [NIB_W-1:0]                       nib_out,
   output logic [$clog2(DATA_W/NIB_W)-1:0]        nib_idx,
   output logic                                   nib_last,
   input  logic                                   nib_ack,
   output logic                                   ovf,
   input  logic                                   ovf_clr
);

   localparam int NNIB  = DATA_W / NIB_W;
   localparam int IDX_W = $clog2(NNIB);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]    wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [DATA_W-1:0]   shreg_q;
   logic [IDX_W-1:0]    idx_q;
   logic                ovf_q, ovf_d;
   logic                pushReq, full, popEn, pushEn, drop;

   // A full FIFO still accepts a push when the serializer pops the head on the
   // same edge, so only a push with no matching pop is dropped.
   always_comb begin
      pushReq = pcpi_ready & pcpi_wr;
      full    = (count_q == CNT_W'(DEPTH));
      popEn   = (state_q == IDLE) && (count_q != '0);
      pushEn  = pushReq && (!full || popEn);
      drop    = pushReq && full && !popEn;
      count_d = count_q;
      if (pushEn && !popEn) begin
         count_d = count_q + CNT_W'(1);
      end else if (!pushEn && popEn) begin
         count_d = count_q - CNT_W'(1);
      end
      ovf_d = drop | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge clk) begin
      if (pushEn) begin
         mem_q[wrPtr_q] <= pcpi_rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         shreg_q <= '0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         if (pushEn) begin
            wrPtr_q <= wrPtr_q + PTR_W'(1);
         end
         case (state_q)
            IDLE: begin
               if (popEn) begin
                  shreg_q <= mem_q[rdPtr_q];
                  rdPtr_q <= rdPtr_q + PTR_W'(1);
                  idx_q   <= '0;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (nib_ack) begin
                  if (idx_q == LAST_IDX) begin
                     state_q <= IDLE;
                  end else begin
                     shreg_q <= shreg_q >> NIB_W;
                     idx_q   <= idx_q + IDX_W'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Nibble outputs are forced to zero outside SEND so reset and idle look identical.
   assign busy      = full;
   assign ovf       = ovf_q;
   assign nib_valid = (state_q == SEND);
   assign nib_out   = nib_valid ? shreg_q[NIB_W-1:0] : '0;
   assign nib_idx   = nib_valid ? idx_q : '0;
   assign nib_last  = nib_valid && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_pcpi_result_serializer.sv
// Scoreboard bench for pcpi_result_serializer: expected words are queued at
// each strobe and compared as the nibble stream reassembles them.
module tb_pcpi_result_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pcpi_ready = 1'b0;
   logic        pcpi_wr = 1'b0;
   logic [31:0] pcpi_rd = '0;
   logic        busy;
   logic        nib_valid;
   logic [3:0]  nib_out;
   logic [2:0]  nib_idx;
   logic        nib_last;
   logic        nib_ack = 1'b0;
   logic        ovf;
   logic        ovf_clr = 1'b0;

   int passed = 0;
   int total  = 0;
   logic [31:0] expQ [$];

   pcpi_result_serializer #(.DATA_W(32), .NIB_W(4), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr),
      .pcpi_rd(pcpi_rd), .busy(busy), .nib_valid(nib_valid), .nib_out(nib_out),
      .nib_idx(nib_idx), .nib_last(nib_last), .nib_ack(nib_ack), .ovf(ovf),
      .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge, where outputs are sampled and inputs change.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [31:0] data, input logic wr, input bit accepted);
      pcpi_ready = 1'b1;
      pcpi_wr    = wr;
      pcpi_rd    = data;
      if (wr && accepted) expQ.push_back(data);
      tick();
      pcpi_ready = 1'b0;
      pcpi_wr    = 1'b0;
   endtask

   // Gathers one word off the nibble port, acking every ackPeriod-th cycle.
   // protoOk drops on a wrong idx/last, an unstable held nibble or a mid-word valid drop.
   task automatic collectWord(input int ackPeriod, output logic [31:0] w,
                              output bit protoOk, output bit timedOut);
      int k = 0;
      int cyc = 0;
      bit held = 0;
      logic [3:0] heldNib = '0;
      bit ack;
      w = '0;
      protoOk = 1;
      timedOut = 0;
      while (k < 8) begin
         if (cyc > 300) begin
            timedOut = 1;
            break;
         end
         if (nib_valid) begin
            ack = ((cyc % ackPeriod) == ackPeriod - 1);
            if (nib_idx !== 3'(k)) protoOk = 0;
            if (nib_last !== (k == 7)) protoOk = 0;
            if (held && nib_out !== heldNib) protoOk = 0;
            nib_ack = ack;
            if (ack) begin
               w[4*k +: 4] = nib_out;
               k++;
               held = 0;
            end else begin
               held = 1;
               heldNib = nib_out;
            end
         end else begin
            nib_ack = 1'b0;
            if (k > 0 || held) protoOk = 0;
         end
         tick();
         cyc++;
      end
      nib_ack = 1'b0;
   endtask

   task automatic test_reset();
      bit quiet = 1;
      rst = 1'b1;
      pcpi_ready = 1'b1;
      pcpi_wr = 1'b1;
      pcpi_rd = 32'hDEADBEEF;
      repeat (3) tick();
      total++; if (nib_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", nib_valid); else passed++;
      total++; if (nib_out !== 4'h0) $display("[TB] FAIL reset_nib_out: got %h expected 0", nib_out); else passed++;
      total++; if (nib_idx !== 3'd0) $display("[TB] FAIL reset_nib_idx: got %0d expected 0", nib_idx); else passed++;
      total++; if (nib_last !== 1'b0) $display("[TB] FAIL reset_nib_last: got %b expected 0", nib_last); else passed++;
      total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
      total++; if (ovf !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); else passed++;
      pcpi_ready = 1'b0;
      pcpi_wr = 1'b0;
      #2 rst = 1'b0;
      repeat (6) begin
         tick();
         if (nib_valid !== 1'b0) quiet = 0;
      end
      total++; if (!quiet) $display("[TB] FAIL post_reset_idle: got valid=1 expected 0"); else passed++;
   endtask

   task automatic runSingle(input int ackPeriod, input string tag);
      logic [31:0] w, exp;
      bit ok, to;
      strobe(32'h89ABCDEF, 1'b1, 1'b1);
      total++; if (nib_valid !== 1'b0) $display("[TB] FAIL %s_latency_e0: got %b expected 0", tag, nib_valid); else passed++;
      tick();
      total++; if (nib_valid !== 1'b1) $display("[TB] FAIL %s_latency_e1: got %b expected 1", tag, nib_valid); else passed++;
      collectWord(ackPeriod, w, ok, to);
      exp = expQ.pop_front();
      total++; if (to) $display("[TB] FAIL %s_timeout: got timeout expected word %h", tag, exp); else passed++;
      total++; if (w !== exp) $display("[TB] FAIL %s_word: got %h expected %h", tag, w, exp); else passed++;
      total++; if (!ok) $display("[TB] FAIL %s_protocol: got bad idx/last/hold expected clean sequence", tag); else passed++;
      total++; if (nib_valid !== 1'b0) $display("[TB] FAIL %s_drop_after_last: got %b expected 0", tag, nib_valid); else passed++;
   endtask

   task automatic test_single();
      runSingle(1, "single");
   endtask

   task automatic test_slow_ack();
      repeat (2) tick();
      runSingle(3, "slow_ack");
   endtask

   task automatic test_no_wr();
      bit quiet = 1;
      strobe(32'h12345678, 1'b0, 1'b1);
      repeat (5) begin
         if (nib_valid !== 1'b0) quiet = 0;
         tick();
      end
      total++; if (!quiet) $display("[TB] FAIL no_wr_valid: got valid=1 expected 0"); else passed++;
      total++; if (busy !== 1'b0) $display("[TB] FAIL no_wr_busy: got %b expected 0", busy); else passed++;
   endtask

   task automatic test_overflow();
      logic [31:0] w, exp;
      bit ok, to;
      nib_ack = 1'b0;
      strobe(32'h11111111, 1'b1, 1'b1);
      strobe(32'h22222222, 1'b1, 1'b1);
      total++; if (busy !== 1'b0) $display("[TB] FAIL ovf_busy_early: got %b expected 0", busy); else passed++;
      strobe(32'h33333333, 1'b1, 1'b1);
      total++; if (busy !== 1'b1) $display("[TB] FAIL ovf_busy_full: got %b expected 1", busy); else passed++;
      total++; if (ovf !== 1'b0) $display("[TB] FAIL ovf_before_drop: got %b expected 0", ovf); else passed++;
      strobe(32'h44444444, 1'b1, 1'b0);
      total++; if (ovf !== 1'b1) $display("[TB] FAIL ovf_set: got %b expected 1", ovf); else passed++;
      repeat (2) tick();
      total++; if (ovf !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b expected 1", ovf); else passed++;
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      total++; if (ovf !== 1'b0) $display("[TB] FAIL ovf_clear: got %b expected 0", ovf); else passed++;
      for (int n = 0; n < 3; n++) begin
         collectWord(1, w, ok, to);
         exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hFFFFFFFF;
         total++; if (to || w !== exp) $display("[TB] FAIL ovf_word%0d: got %h expected %h", n, w, exp); else passed++;
         total++; if (!ok) $display("[TB] FAIL ovf_protocol%0d: got bad sequence expected clean", n); else passed++;
         total++; if (nib_valid !== 1'b0) $display("[TB] FAIL ovf_gap%0d: got %b expected 0", n, nib_valid); else passed++;
         if (n < 2) begin
            tick();
            total++; if (nib_valid !== 1'b1) $display("[TB] FAIL ovf_next%0d: got %b expected 1", n, nib_valid); else passed++;
         end
      end
      repeat (3) tick();
      total++; if (nib_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL ovf_drained: got valid=%b busy=%b expected 0 0", nib_valid, busy); else passed++;
   endtask

   task automatic test_reset_midword();
      logic [31:0] w, exp;
      bit ok, to;
      bit quiet = 1;
      int guard = 0;
      strobe(32'hCAFE1234, 1'b1, 1'b1);
      strobe(32'h5555AAAA, 1'b1, 1'b1);
      nib_ack = 1'b1;
      while (!(nib_valid && nib_idx == 3'd3) && guard < 50) begin
         tick();
         guard++;
      end
      nib_ack = 1'b0;
      total++; if (guard >= 50) $display("[TB] FAIL midword_reach_idx3: got timeout expected idx 3"); else passed++;
      #2 rst = 1'b1;
      #1;
      total++; if (nib_valid !== 1'b0) $display("[TB] FAIL midword_async_reset: got %b expected 0", nib_valid); else passed++;
      expQ.delete();
      #3 rst = 1'b0;
      repeat (5) begin
         tick();
         if (nib_valid !== 1'b0) quiet = 0;
      end
      total++; if (!quiet || busy !== 1'b0) $display("[TB] FAIL midword_fifo_empty: got valid-seen=%b busy=%b expected 0 0", !quiet, busy); else passed++;
      strobe(32'h0F1E2D3C, 1'b1, 1'b1);
      collectWord(1, w, ok, to);
      exp = expQ.pop_front();
      total++; if (to || w !== exp) $display("[TB] FAIL midword_next_word: got %h expected %h", w, exp); else passed++;
      total++; if (!ok) $display("[TB] FAIL midword_next_protocol: got bad sequence expected idx from 0"); else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_slow_ack();
      test_no_wr();
      test_overflow();
      test_reset_midword();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
